// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//
// N-channel, counter-based push-button debouncer for the clock's set / mode /
// alarm buttons. Each channel is fully independent:
//
//   inp[i] -> sync1 -> sync2 -> stability counter -> outp[i] (+ rise/fall)
//
// The two-flop synchroniser brings the asynchronous button level into the
// cclk domain. The stability counter then requires the synchronised level to
// differ from the current debounced level for STABLE_TICKS consecutive cycles
// before outp follows it. A single cycle back at the old level clears the
// count, so any bounce shorter than STABLE_TICKS is fully absorbed.
//
// rise/fall are registered one-cycle pulses. They assert in the same cycle
// that outp changes. A clean input step sampled into sync1 at edge k shows on
// outp (and rise/fall) at edge k+1+STABLE_TICKS.
//
// Optional feature (compile-time macro DEBOUNCE_AUTOREPEAT_EN):
//   While a button stays pressed, extra rise pulses are generated. The first
//   comes REPEAT_DELAY cycles after the press pulse, and the rest follow every
//   REPEAT_PERIOD cycles. Repeats stop in the cycle outp returns to 0; fall is
//   unaffected. With the macro undefined, no repeat logic exists and the
//   REPEAT_* parameters have no effect.
//
// Parameters
//   N              number of button channels (>= 1)
//   STABLE_TICKS   cycles the synchronised input must differ from outp (>= 1)
//   REPEAT_DELAY   press pulse to first auto-repeat pulse, in cycles (>= 1)
//   REPEAT_PERIOD  spacing of subsequent auto-repeat pulses, in cycles (>= 1)
//
// Ports
//   cclk        in   1  system clock; all logic on posedge
//   clr         in   1  synchronous active-high reset
//   inp  [N-1:0] in      raw asynchronous button inputs, active-high
//   outp [N-1:0] out     debounced level (registered)
//   rise [N-1:0] out     one-cycle pulse on debounced 0->1 (and auto-repeat)
//   fall [N-1:0] out     one-cycle pulse on debounced 1->0
// -----------------------------------------------------------------------------
module debounce_multi #(
  parameter int N             = 4,
  parameter int STABLE_TICKS  = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic         cclk,
  input  logic         clr,
  input  logic [N-1:0] inp,
  output logic [N-1:0] outp,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  // Stability counter: it only ever holds 0 .. STABLE_TICKS-1.
  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  // Legal configuration flag. The empty block below keeps every parameter
  // referenced in both builds; an illegal setting shows up as this block
  // existing in the elaborated hierarchy.
  localparam bit CFG_OK = (N >= 1) && (STABLE_TICKS >= 1) &&
                          (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

  if (!CFG_OK) begin : g_illegal_config
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  // The repeat counter only ever holds 0 .. max(DELAY, PERIOD)-1.
  localparam int RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W    = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);
`endif

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_ch

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] cnt_reg,  cnt_next;
    logic             outp_reg, outp_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;

    // Debounced edges detected by the stability counter, before any
    // auto-repeat pulses are merged into rise.
    logic             edge_rise;
    logic             edge_fall;

    // -------------------------------------------------------------------
    // Stability counter and debounced level
    // -------------------------------------------------------------------
    always_comb begin
      cnt_next  = '0;
      outp_next = outp_reg;
      edge_rise = 1'b0;
      edge_fall = 1'b0;
      if (sync2_reg != outp_reg) begin
        if (cnt_reg == CNT_LAST) begin
          // Input has disagreed for STABLE_TICKS cycles: accept it and
          // restart the count from zero for the next transition.
          outp_next = sync2_reg;
          edge_rise = sync2_reg;
          edge_fall = ~sync2_reg;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      // sync2 == outp leaves cnt_next at 0: a glitch that returns to the
      // old level throws away all progress.
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    // -------------------------------------------------------------------
    // Auto-repeat
    //
    // rpt_reg counts cycles since the last press or repeat pulse.
    // rpt_phase_reg selects the target: 0 means waiting out the initial
    // REPEAT_DELAY after the press pulse, 1 means steady REPEAT_PERIOD
    // repetition. Both are held at 0 whenever outp is 0. Counting starts
    // on the edge after the press pulse, so the first repeat lands exactly
    // REPEAT_DELAY cycles after it.
    // -------------------------------------------------------------------
    logic [RPT_W-1:0] rpt_reg, rpt_next;
    logic             rpt_phase_reg, rpt_phase_next;
    logic             rpt_fire;

    always_comb begin
      rpt_next       = '0;
      rpt_phase_next = 1'b0;
      rpt_fire       = 1'b0;
      // Only while outp is high and stays high this cycle. A repeat that
      // would collide with the release edge is suppressed.
      if (outp_reg && outp_next) begin
        rpt_phase_next = rpt_phase_reg;
        if (rpt_reg == (rpt_phase_reg ? PER_LAST : DLY_LAST)) begin
          rpt_fire       = 1'b1;
          rpt_phase_next = 1'b1;
        end else begin
          rpt_next = rpt_reg + 1'b1;
        end
      end
    end

    always_ff @(posedge cclk) begin
      if (clr) begin
        rpt_reg       <= '0;
        rpt_phase_reg <= 1'b0;
      end else begin
        rpt_reg       <= rpt_next;
        rpt_phase_reg <= rpt_phase_next;
      end
    end

    always_comb begin
      rise_next = edge_rise | rpt_fire;
      fall_next = edge_fall;
    end
`else
    always_comb begin
      rise_next = edge_rise;
      fall_next = edge_fall;
    end
`endif

    // -------------------------------------------------------------------
    // State registers. Reset clears the synchroniser too, so a button held
    // through reset is reported as a fresh press after the full latency.
    // -------------------------------------------------------------------
    always_ff @(posedge cclk) begin
      if (clr) begin
        sync1_reg <= 1'b0;
        sync2_reg <= 1'b0;
        cnt_reg   <= '0;
        outp_reg  <= 1'b0;
        rise_reg  <= 1'b0;
        fall_reg  <= 1'b0;
      end else begin
        sync1_reg <= inp[gi];
        sync2_reg <= sync1_reg;
        cnt_reg   <= cnt_next;
        outp_reg  <= outp_next;
        rise_reg  <= rise_next;
        fall_reg  <= fall_next;
      end
    end

    assign outp[gi] = outp_reg;
    assign rise[gi] = rise_reg;
    assign fall[gi] = fall_reg;

  end

endmodule

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
//
// Directed bench for debounce_multi (N=4, STABLE_TICKS=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=4). The stimulus process drives inp/clr on the falling edge.
// Whenever it creates a debounced transition, it pushes the expected output
// event (cycle stamp, rise, fall, outp) into a queue. A separate monitor
// process watches every falling edge and pops and compares an entry whenever
// the DUT shows a rise or fall pulse. Expected events whose cycle has passed
// without a pulse are reported as missed.
//
// Cycle stamping: cyc counts rising edges. An input driven while cyc == c is
// sampled into sync1 at edge c+1, so its debounced event appears at edge
// c+1+1+STABLE_TICKS = c+LAT.
// -----------------------------------------------------------------------------
module tb_debounce_multi;

  localparam int N   = 4;
  localparam int ST  = 4;
  localparam int RD  = 8;
  localparam int RP  = 4;
  localparam int LAT = ST + 2;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic [N-1:0] inp = '0;
  logic [N-1:0] outp;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int           at;
    logic [N-1:0] r;
    logic [N-1:0] f;
    logic [N-1:0] o;
  } ev_t;

  ev_t exp_q[$];

  debounce_multi #(
    .N            (N),
    .STABLE_TICKS (ST),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .cclk (clk),
    .clr  (clr),
    .inp  (inp),
    .outp (outp),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int at, input logic [N-1:0] r,
                         input logic [N-1:0] f, input logic [N-1:0] o);
    ev_t e;
    e.at = at;
    e.r  = r;
    e.f  = f;
    e.o  = o;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Quiet check used while the design is held in or just out of reset.
  task automatic check_quiet(input string name);
    tests++;
    if (outp !== '0 || rise !== '0 || fall !== '0) begin
      fails++;
      $display("[TB] FAIL %s: got outp=%h rise=%h fall=%h, want all 0",
               name, outp, rise, fall);
    end else begin
      $display("[TB] ok   %s: outp=%h rise=%h fall=%h", name, outp, rise, fall);
    end
  endtask

  // ---------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("[TB] FAIL missed_event: nothing seen at cyc=%0d, want rise=%h fall=%h outp=%h",
               e.at, e.r, e.f, e.o);
    end
    if ((rise | fall) !== '0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_event: got cyc=%0d rise=%h fall=%h outp=%h, want no pulse",
                 cyc, rise, fall, outp);
      end else begin
        e = exp_q.pop_front();
        if (e.at != cyc || e.r !== rise || e.f !== fall || e.o !== outp) begin
          fails++;
          $display("[TB] FAIL event: got cyc=%0d rise=%h fall=%h outp=%h, want cyc=%0d rise=%h fall=%h outp=%h",
                   cyc, rise, fall, outp, e.at, e.r, e.f, e.o);
        end else begin
          $display("[TB] ok   event: cyc=%0d rise=%h fall=%h outp=%h",
                   cyc, rise, fall, outp);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int c;
    int s0;

    // 1. Reset held for two cycles with all buttons pressed.
    idle(1);
    inp = 4'hF;
    for (int i = 0; i < 2; i++) begin
      idle(1);
      check_quiet("reset_hold");
    end
    clr = 1'b0;
    push_ev(cyc + LAT, 4'hF, 4'h0, 4'hF);   // held through reset = fresh press
    idle(12);

    // Release everything together.
    inp = 4'h0;
    push_ev(cyc + LAT, 4'h0, 4'hF, 4'h0);
    idle(12);

    // 2. Single clean press on channel 0.
    inp[0] = 1'b1;
    push_ev(cyc + LAT, 4'h1, 4'h0, 4'h1);
    idle(12);

    // 3. Channel 1 glitches: 1 cycle high, 5 low, 3 high. No event expected.
    inp[1] = 1'b1; idle(1);
    inp[1] = 1'b0; idle(5);
    inp[1] = 1'b1; idle(3);
    inp[1] = 1'b0; idle(12);

    // 4. Channel 2 press, then release.
    inp[2] = 1'b1;
    push_ev(cyc + LAT, 4'h4, 4'h0, 4'h5);
    idle(12);
    inp[2] = 1'b0;
    push_ev(cyc + LAT, 4'h0, 4'h4, 4'h1);
    idle(12);

    // Simultaneous: ch0 releases while ch1 and ch2 press in the same cycle.
    inp = 4'b0110;
    push_ev(cyc + LAT, 4'h6, 4'h1, 4'h6);
    idle(12);
    inp = 4'h0;
    push_ev(cyc + LAT, 4'h0, 4'h6, 4'h0);
    idle(12);

    // 5. Channel 3 press, reset pulse one cycle before outp would change.
    c = cyc;
    inp[3] = 1'b1;
    idle(4);                 // cnt has reached 2; outp would flip at edge c+6
    clr = 1'b1;
    idle(1);                 // reset edge c+5
    check_quiet("reset_midcount");
    clr = 1'b0;
    push_ev(cyc + LAT, 4'h8, 4'h0, 4'h8);   // full latency after clr falls
    idle(12);
    inp[3] = 1'b0;
    push_ev(cyc + LAT, 4'h0, 4'h8, 4'h0);
    idle(12);

    // 6. Channel 0 held for 30 cycles.
    s0 = cyc;
    inp[0] = 1'b1;
    push_ev(s0 + LAT, 4'h1, 4'h0, 4'h1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    // Repeats at T+8, then every 4, strictly before the release edge.
    for (int t = s0 + LAT + RD; t < s0 + 30 + LAT; t += RP)
      push_ev(t, 4'h1, 4'h0, 4'h1);
`endif
    idle(30);
    inp[0] = 1'b0;
    push_ev(cyc + LAT, 4'h0, 4'h1, 4'h0);
    idle(15);

    // Every expected event must have been consumed.
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL leftover_events: got %0d pending, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
